mips_fetch_queue: RTL

- Instruction fetch front-end that sits directly upstream of mips_cpu, between instruction_memory and the CPU's instruction input.
- Autonomously fetches sequential words from instruction memory over a req/ack port and buffers {pc, instr} pairs in a small FIFO.
- Presents the queue head to the CPU with a valid/ready handshake.
- A redirect (taken branch/jump) flushes the queue and restarts fetch at the new PC.

---
 rtl/mips_fetch_queue_pkg.sv | 18 +
 rtl/mips_fetch_queue_if.sv | 31 +++
 rtl/mips_fetch_queue_fifo.sv | 61 ++++++
 rtl/mips_fetch_queue.sv | 84 ++++++++
 4 files changed

// File: rtl/mips_fetch_queue_pkg.sv
// Shared widths, entry layout and address helpers for the instruction fetch queue.
package mips_fetch_queue_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned PC_W    = 32;
    localparam logic [PC_W-1:0] PC_STEP = 32'd4;

    // One queue slot: {pc[31:0], instr[31:0]}
    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fq_entry_t;

    function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] a);
        return {a[PC_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/mips_fetch_queue_if.sv
// Fetch queue bus: instruction-memory request port, CPU-side head handshake and redirect.
interface mips_fetch_queue_if #(
    parameter int unsigned DEPTH = 4
);
    import mips_fetch_queue_pkg::*;

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic               imem_req;
    logic [PC_W-1:0]    imem_a;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rd;
    logic               redirect;
    logic [PC_W-1:0]    redirect_pc;
    logic               instr_valid;
    logic               instr_ready;
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    instr_pc;
    logic [CNT_W-1:0]   count;

    modport master (
        output imem_req, imem_a, instr_valid, instr, instr_pc, count,
        input  imem_ack, imem_rd, redirect, redirect_pc, instr_ready
    );

    modport slave (
        input  imem_req, imem_a, instr_valid, instr, instr_pc, count,
        output imem_ack, imem_rd, redirect, redirect_pc, instr_ready
    );

endinterface

// File: rtl/mips_fetch_queue_fifo.sv
// fq_fifo: DEPTH x {pc, instr} FIFO with flush priority and combinational head read.
module fq_fifo
    import mips_fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  fq_entry_t                  push_data,
    output fq_entry_t                  head_data,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CNT_W = AW + 1;

    fq_entry_t        mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             full;
    logic             empty;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !flush && !full;
    assign do_pop  = pop && !flush && !empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Empty head reads as zero so stale slots never leak onto the CPU side
    assign head_data = empty ? '0 : mem[rptr];

endmodule

// File: rtl/mips_fetch_queue.sv
// Sequential instruction prefetch queue with redirect flush.
// Optional MIPS_FETCH_QUEUE_PERF_EN adds saturating fetch/flush counters.
module mips_fetch_queue
    import mips_fetch_queue_pkg::*;
#(
    parameter int unsigned     DEPTH    = 4,
    parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst_n,
    mips_fetch_queue_if.master bus
`ifdef MIPS_FETCH_QUEUE_PERF_EN
    ,
    output logic [15:0]        perf_fetched,
    output logic [15:0]        perf_flushed
`endif
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [PC_W-1:0]  fetch_pc;
    logic             req_en;
    logic             full;
    logic             push;
    logic             pop;
    logic [CNT_W-1:0] count;
    fq_entry_t        push_data;
    fq_entry_t        head_data;

    // Requests start one edge after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) req_en <= 1'b0;
        else        req_en <= 1'b1;
    end

    assign full         = (count == CNT_W'(DEPTH));
    assign bus.imem_req = req_en && !full && !bus.redirect;
    assign bus.imem_a   = fetch_pc;
    assign push         = bus.imem_req && bus.imem_ack;
    assign pop          = bus.instr_valid && bus.instr_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc <= RESET_PC;
        end else if (bus.redirect) begin
            fetch_pc <= align_pc(bus.redirect_pc);
        end else if (push) begin
            fetch_pc <= fetch_pc + PC_STEP;
        end
    end

    assign push_data.pc    = fetch_pc;
    assign push_data.instr = bus.imem_rd;

    fq_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (bus.redirect),
        .push      (push),
        .pop       (pop),
        .push_data (push_data),
        .head_data (head_data),
        .count     (count)
    );

    assign bus.count       = count;
    assign bus.instr_valid = (count != '0);
    assign bus.instr       = head_data.instr;
    assign bus.instr_pc    = head_data.pc;

`ifdef MIPS_FETCH_QUEUE_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched <= '0;
            perf_flushed <= '0;
        end else begin
            if (push && perf_fetched != '1)         perf_fetched <= perf_fetched + 16'd1;
            if (bus.redirect && perf_flushed != '1) perf_flushed <= perf_flushed + 16'd1;
        end
    end
`endif

endmodule
